// File: rtl/config_pkg.sv
// Minimal core configuration package for the frontend duplication stage.
// Only the address width is carried; other core fields are not needed here.
// No logic: pure type and constant definitions.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 64};

endpackage

// File: rtl/ftsr_dup_issue_if.sv
// Handshake bundle between the scanner, the duplication stage and the instruction queue.
// Latency: none, wires only.
// Backpressure: valid/ready on both the upstream (valid_i/ready_o) and downstream (valid_o/ready_i) sides.
interface ftsr_dup_issue_if #(
  parameter int unsigned VLEN  = 64,
  parameter int unsigned SEQ_W = 3
);

  // Upstream side: scanner to stage
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      instr_i;
  logic [VLEN-1:0]  addr_i;
  logic             redundant_i;

  // Downstream side: stage to instruction queue
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      instr_o;
  logic [VLEN-1:0]  addr_o;
  logic             shadow_o;
  logic             dup_o;
  logic [SEQ_W-1:0] seq_o;

  // Environment view: drives scanner outputs and the queue ready
  modport master (
    output valid_i, instr_i, addr_i, redundant_i, ready_i,
    input  ready_o, valid_o, instr_o, addr_o, shadow_o, dup_o, seq_o
  );

  // Stage view
  modport slave (
    input  valid_i, instr_i, addr_i, redundant_i, ready_i,
    output ready_o, valid_o, instr_o, addr_o, shadow_o, dup_o, seq_o
  );

endinterface

// File: rtl/ftsr_dup_issue.sv
// FTSR duplication stage: buffers scanned instructions, emits redundant ones twice (primary, shadow).
// Latency: 1 cycle minimum from push to output (no bypass); redundant entries occupy 2 output beats.
// Backpressure: ready_o drops when the FIFO is full or on flush; output holds stable while ready_i is low.
// Optional macro FTSR_DUP_STATS_EN adds dup_cnt_o, a saturating count of shadow copies handed off.
module ftsr_dup_issue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        ftsr_en_i,
`ifdef FTSR_DUP_STATS_EN
  output logic [31:0] dup_cnt_o,
`endif
  ftsr_dup_issue_if.slave bus
);

  localparam int unsigned VLEN  = CVA6Cfg.VLEN;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    PRIM = 1'b0,
    SHAD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  // Entry storage, one array per field of {instr, addr, dup, seq}
  logic [31:0]      instr_mem_q [DEPTH];
  logic [VLEN-1:0]  addr_mem_q  [DEPTH];
  logic [SEQ_W-1:0] seq_mem_q   [DEPTH];
  logic [DEPTH-1:0] dup_mem_q;

  logic empty;
  logic full;
  logic in_rdy;
  logic out_vld;
  logic push;
  logic pop;
  logic fire;
  logic head_dup;

  // Handshake decode and output FSM; flush overrides every next-state value
  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNT_W'(DEPTH));
    in_rdy   = ~full & ~flush_i & ~rst_i;
    push     = bus.valid_i & in_rdy;
    head_dup = ~empty & dup_mem_q[rd_ptr_q];
    out_vld  = 1'b0;
    pop      = 1'b0;
    state_d  = state_q;

    case (state_q)
      PRIM: begin
        out_vld = ~empty & ~flush_i & ~rst_i;
        if (out_vld && bus.ready_i) begin
          // A duplicated head stays put until its shadow copy is taken
          if (head_dup) state_d = SHAD;
          else          pop     = 1'b1;
        end
      end
      SHAD: begin
        out_vld = ~flush_i & ~rst_i;
        if (out_vld && bus.ready_i) begin
          pop     = 1'b1;
          state_d = PRIM;
        end
      end
      default: state_d = PRIM;
    endcase

    fire = out_vld & bus.ready_i;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    seq_d    = push ? seq_q + SEQ_W'(1)    : seq_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Flush discards everything, including a pending shadow copy
    if (flush_i) begin
      state_d  = PRIM;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      seq_d    = '0;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PRIM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
    end
  end

  // Entry write; duplication decision is frozen at enqueue time
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.instr_i;
      addr_mem_q[wr_ptr_q]  <= bus.addr_i;
      seq_mem_q[wr_ptr_q]   <= seq_q;
      dup_mem_q[wr_ptr_q]   <= bus.redundant_i & ftsr_en_i;
    end
  end

  assign bus.ready_o  = in_rdy;
  assign bus.valid_o  = out_vld;
  assign bus.shadow_o = (state_q == SHAD);
  assign bus.dup_o    = head_dup;
  assign bus.instr_o  = empty ? '0 : instr_mem_q[rd_ptr_q];
  assign bus.addr_o   = empty ? '0 : addr_mem_q[rd_ptr_q];
  assign bus.seq_o    = empty ? '0 : seq_mem_q[rd_ptr_q];

`ifdef FTSR_DUP_STATS_EN
  logic [31:0] dup_cnt_q;

  // Saturating count of accepted shadow copies; survives flush, cleared by reset only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dup_cnt_q <= '0;
    end else if ((state_q == SHAD) && bus.ready_i && !flush_i && (dup_cnt_q != 32'hFFFF_FFFF)) begin
      dup_cnt_q <= dup_cnt_q + 32'd1;
    end
  end

  assign dup_cnt_o = dup_cnt_q;
`endif

  // fire is kept for readability of the FSM; reference it so it is not flagged as unused
  logic unused_fire;
  assign unused_fire = fire;

endmodule

// File: tb/tb_ftsr_dup_issue.sv
// Self-checking bench for ftsr_dup_issue: scoreboard of expected beats vs. monitored handshakes.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task drives its stimulus and compares inline.
module tb_ftsr_dup_issue;

  localparam int VLEN = 64;

  typedef struct packed {
    logic [31:0]     instr;
    logic [VLEN-1:0] addr;
    logic            shadow;
    logic            dup;
    logic [2:0]      seq;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic ftsr_en;
`ifdef FTSR_DUP_STATS_EN
  logic [31:0] dup_cnt;
`endif

  ftsr_dup_issue_if #(.VLEN(VLEN), .SEQ_W(3)) bus ();

  ftsr_dup_issue #(
    .DEPTH (4),
    .SEQ_W (3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .ftsr_en_i (ftsr_en),
`ifdef FTSR_DUP_STATS_EN
    .dup_cnt_o (dup_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [2:0] m_seq;

  // Record every output beat that is handed off at the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.valid_o && bus.ready_i)
      obs_q.push_back(beat_t'{bus.instr_o, bus.addr_o, bus.shadow_o, bus.dup_o, bus.seq_o});
  end

  task automatic exp_push(input logic [31:0] ins, input logic [VLEN-1:0] a, input logic d);
    exp_q.push_back(beat_t'{ins, a, 1'b0, d, m_seq});
    if (d) exp_q.push_back(beat_t'{ins, a, 1'b1, d, m_seq});
    m_seq = m_seq + 3'd1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [VLEN-1:0] a, input logic r);
    @(posedge clk); #1;
    bus.valid_i     = v;
    bus.instr_i     = ins;
    bus.addr_i      = a;
    bus.redundant_i = r;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); obs_q.delete(); m_seq = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ftsr_en = 1'b1;
    bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.instr_i = 32'hDEAD_BEEF;
    bus.addr_i = 64'h1234; bus.redundant_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.ready_o); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
    total++; if (bus.shadow_o !== 1'b0) begin bad++; $display("FAIL rst_shadow: got %b want 0", bus.shadow_o); end
    total++; if (bus.dup_o !== 1'b0) begin bad++; $display("FAIL rst_dup: got %b want 0", bus.dup_o); end
    total++; if (bus.seq_o !== 3'd0) begin bad++; $display("FAIL rst_seq: got %0d want 0", bus.seq_o); end
    total++; if (bus.instr_o !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h want 0", bus.instr_o); end
    total++; if (bus.addr_o !== 64'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.addr_o); end
    @(posedge clk); #1;
    rst = 1'b0; bus.valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", bus.ready_o); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", bus.valid_o); end
    exp_q.delete(); obs_q.delete(); m_seq = 3'd0;
  endtask

  task automatic test_single();
    beat_t e, o;
    int guard;
    do_reset();
    ftsr_en = 1'b1; bus.ready_i = 1'b1;
    drive(1'b1, 32'h00A0_0093, 64'h8000_0000, 1'b0);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.ready_o); end
    exp_push(32'h00A0_0093, 64'h8000_0000, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.shadow_o !== 1'b0) begin bad++; $display("FAIL single_shadow: got %b want 0", bus.shadow_o); end
    total++; if (bus.seq_o !== 3'd0) begin bad++; $display("FAIL single_seq: got %0d want 0", bus.seq_o); end
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus.valid_o); end
    // Redundant flag with duplication disabled; enable rises after enqueue
    ftsr_en = 1'b0;
    drive(1'b1, 32'h00C0_0113, 64'h8000_0004, 1'b1);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL nodup_ready: got %b want 1", bus.ready_o); end
    exp_push(32'h00C0_0113, 64'h8000_0004, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    ftsr_en = 1'b1;
    @(negedge clk);
    total++; if (bus.dup_o !== 1'b0) begin bad++; $display("FAIL nodup_dup: got %b want 0", bus.dup_o); end
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 64) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL single_beat: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    int guard;
    logic [4:0] red_pat;
    do_reset();
    ftsr_en = 1'b1; bus.ready_i = 1'b1;
    drive(1'b1, 32'h00B5_0533, 64'h8000_0008, 1'b1);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL red_ready: got %b want 1", bus.ready_o); end
    exp_push(32'h00B5_0533, 64'h8000_0008, 1'b1);
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    @(negedge clk);
    total++; if ({bus.valid_o, bus.shadow_o, bus.dup_o} !== 3'b101) begin bad++; $display("FAIL red_prim: got %b want 101", {bus.valid_o, bus.shadow_o, bus.dup_o}); end
    @(negedge clk);
    total++; if ({bus.valid_o, bus.shadow_o, bus.dup_o} !== 3'b111) begin bad++; $display("FAIL red_shad: got %b want 111", {bus.valid_o, bus.shadow_o, bus.dup_o}); end
    total++; if (bus.instr_o !== 32'h00B5_0533) begin bad++; $display("FAIL red_shad_instr: got %h want 00b50533", bus.instr_o); end
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL red_idle: got %b want 0", bus.valid_o); end
    #1;
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL red_beats: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL red_beat: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    // Plain stream: one beat per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000_0000 + 32'(i), 64'h8000_0100 + 64'(4 * i), 1'b0);
      @(negedge clk);
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", bus.ready_o); end
      exp_push(32'h2000_0000 + 32'(i), 64'h8000_0100 + 64'(4 * i), 1'b0);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    @(negedge clk); #1;
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL b2b_rate: got %0d want 4", obs_q.size()); end
    // Mixed stream of redundant and plain entries
    red_pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000_0000 + 32'(i), 64'h8000_0200 + 64'(4 * i), red_pat[i]);
      @(negedge clk);
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL mix_ready: got %b want 1", bus.ready_o); end
      exp_push(32'h3000_0000 + 32'(i), 64'h8000_0200 + 64'(4 * i), red_pat[i]);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 64) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mix_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL mix_beat: got %h want %h", o, e); end
    end
  endtask

  task automatic test_full();
    beat_t e, o;
    int guard;
    logic exp_rdy;
    logic r;
    do_reset();
    ftsr_en = 1'b1; bus.ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = (i == 1);
      drive(1'b1, 32'h1000_0000 + 32'(i), 64'h8000_1000 + 64'(4 * i), r);
      @(negedge clk);
      exp_rdy = (i < 4);
      total++; if (bus.ready_o !== exp_rdy) begin bad++; $display("FAIL full_ready%0d: got %b want %b", i, bus.ready_o, exp_rdy); end
      if (exp_rdy) exp_push(32'h1000_0000 + 32'(i), 64'h8000_1000 + 64'(4 * i), r);
    end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", bus.valid_o); end
    @(negedge clk);
    total++; if (bus.instr_o !== 32'h1000_0000) begin bad++; $display("FAIL bp_instr: got %h want 10000000", bus.instr_o); end
    total++; if (bus.seq_o !== 3'd0) begin bad++; $display("FAIL bp_seq: got %0d want 0", bus.seq_o); end
    // Pop while full: the offered entry must still be refused
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL full_pop_ready: got %b want 0", bus.ready_o); end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 64) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL full_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL full_beat: got %h want %h", o, e); end
    end
  endtask

  task automatic test_flush();
    beat_t e, o;
    int guard;
    do_reset();
    ftsr_en = 1'b1; bus.ready_i = 1'b0;
    drive(1'b1, 32'h4000_0000, 64'h8000_2000, 1'b1);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL fl_ready_a: got %b want 1", bus.ready_o); end
    drive(1'b1, 32'h4000_0001, 64'h8000_2004, 1'b0);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL fl_ready_b: got %b want 1", bus.ready_o); end
    // Only the primary of A escapes before the flush
    exp_q.push_back(beat_t'{32'h4000_0000, 64'h8000_2000, 1'b0, 1'b1, 3'd0});
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    bus.ready_i = 1'b1;
    @(negedge clk);
    total++; if ({bus.valid_o, bus.shadow_o} !== 2'b10) begin bad++; $display("FAIL fl_prim: got %b want 10", {bus.valid_o, bus.shadow_o}); end
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    total++; if ({bus.valid_o, bus.shadow_o} !== 2'b11) begin bad++; $display("FAIL fl_shad: got %b want 11", {bus.valid_o, bus.shadow_o}); end
    drive(1'b1, 32'h4000_00FF, 64'h8000_20FF, 1'b0);
    flush = 1'b1; bus.ready_i = 1'b1;
    @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", bus.valid_o); end
    total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b want 0", bus.ready_o); end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    total++; if ({bus.valid_o, bus.shadow_o, bus.dup_o} !== 3'b000) begin bad++; $display("FAIL fl_after: got %b want 000", {bus.valid_o, bus.shadow_o, bus.dup_o}); end
    m_seq = 3'd0;
    drive(1'b1, 32'h4000_0002, 64'h8000_2008, 1'b0);
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL fl_ready_c: got %b want 1", bus.ready_o); end
    exp_push(32'h4000_0002, 64'h8000_2008, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    @(negedge clk);
    total++; if (bus.seq_o !== 3'd0) begin bad++; $display("FAIL fl_seq: got %0d want 0", bus.seq_o); end
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 64) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL fl_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) begin bad++; $display("FAIL fl_beat: got %h want %h", o, e); end
    end
  endtask

`ifdef FTSR_DUP_STATS_EN
  task automatic test_stats();
    logic [4:0] red_pat;
    do_reset();
    ftsr_en = 1'b1; bus.ready_i = 1'b1;
    red_pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h5000_0000 + 32'(i), 64'h8000_3000 + 64'(4 * i), red_pat[i]);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    total++; if (dup_cnt !== 32'd3) begin bad++; $display("FAIL stats_cnt: got %0d want 3", dup_cnt); end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    total++; if (dup_cnt !== 32'd3) begin bad++; $display("FAIL stats_flush: got %0d want 3", dup_cnt); end
    do_reset();
    @(negedge clk);
    total++; if (dup_cnt !== 32'd0) begin bad++; $display("FAIL stats_rst: got %0d want 0", dup_cnt); end
  endtask
`endif

  initial begin
    m_seq = 3'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_flush();
`ifdef FTSR_DUP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
